// File: rtl/gmux_pkg.sv
// Shared types and helpers for the global clock mux select sequencer.
package gmux_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GATE_OFF = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_REVERT   = 3'd4,
    ST_GATE_ON  = 3'd5
  } gmux_state_e;

  localparam int SETTLE_W = 8;
  localparam int MAX_SRC  = 16;
  localparam int IDX_W    = 4;

  function automatic logic [MAX_SRC-1:0] onehot_dec(input logic [IDX_W-1:0] idx);
    onehot_dec = {{(MAX_SRC-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/gmux_settle_cnt.sv
// Saturating settle timer: load arms it, done rises SETTLE_CYC edges after the load edge.
module gmux_settle_cnt
  import gmux_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_done
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYC - 1);
  localparam logic [SETTLE_W-1:0] ZERO     = {SETTLE_W{1'b0}};
  localparam logic [SETTLE_W-1:0] ONE      = {{(SETTLE_W-1){1'b0}}, 1'b1};

  logic [SETTLE_W-1:0] r_cnt;

  // down-counter, holds at zero once expired
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != ZERO) begin
      r_cnt <= r_cnt - ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == ZERO);

endmodule

// File: rtl/gmux_sel_seq.sv
// Handshaked select sequencer for a cascade of global clock muxes:
// gate off, settle, change select, settle, gate on; reverts if the target clock disappears.
module gmux_sel_seq
  import gmux_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int SEL_W      = $clog2(N_SRC),
  parameter int SETTLE_CYC = 4,
  parameter int DEF_SRC    = 0
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             REQ_VALID,
  input  logic [SEL_W-1:0] REQ_SRC,
  output logic             REQ_READY,
  input  logic [N_SRC-1:0] SRC_ACTIVE,
  output logic [SEL_W-1:0] SEL,
  output logic [N_SRC-1:0] SEL_OH,
  output logic             GATE_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int               N_PAD     = 1 << SEL_W;
  localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEF_SRC);
  localparam logic [SEL_W:0]   N_SRC_CMP = (SEL_W+1)'(N_SRC);
  localparam logic [N_SRC-1:0] DEF_OH    = {{(N_SRC-1){1'b0}}, 1'b1} << DEF_SRC;

  gmux_state_e         r_state;
  gmux_state_e         w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [N_SRC-1:0]    r_sel_oh;
  logic [SEL_W-1:0]    r_tgt;
  logic [SEL_W-1:0]    w_tgt_nxt;
  logic [SEL_W-1:0]    r_prev;
  logic [SEL_W-1:0]    w_prev_nxt;
  logic                r_gate_en;
  logic                w_gate_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_cnt_load;
  logic                w_cnt_done;
  logic [N_PAD-1:0]    w_act_pad;
  logic [IDX_W-1:0]    w_idx;
  logic [MAX_SRC-1:0]  w_oh_full;
  logic                w_unused_oh;
  logic                w_req_oob;
  logic                w_req_act;
  logic                w_tgt_act;
  logic                w_accept;

  gmux_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .i_clk  (QCK),
    .i_rst  (QRT),
    .i_load (w_cnt_load),
    .o_done (w_cnt_done)
  );

  // pad the status vector to the full index range so any REQ_SRC indexes safely
  always_comb begin
    w_act_pad              = {N_PAD{1'b0}};
    w_act_pad[N_SRC-1:0]   = SRC_ACTIVE;
  end

  assign w_req_oob = ({1'b0, REQ_SRC} >= N_SRC_CMP);
  assign w_req_act = w_act_pad[REQ_SRC];
  assign w_tgt_act = w_act_pad[r_tgt];
  assign w_accept  = REQ_VALID && r_ready;

  // next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_tgt_nxt   = r_tgt;
    w_prev_nxt  = r_prev;
    w_gate_nxt  = r_gate_en;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_load  = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      // GATE_ON is the first idle cycle after a completed switch and accepts requests
      ST_IDLE, ST_GATE_ON: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_req_oob) begin
            w_err_nxt = 1'b1;
          end else if (!w_req_act) begin
            w_err_nxt = 1'b1;
          end else if (REQ_SRC == r_sel) begin
            w_done_nxt = 1'b1;
          end else begin
            w_tgt_nxt   = REQ_SRC;
            w_prev_nxt  = r_sel;
            w_state_nxt = ST_GATE_OFF;
            w_gate_nxt  = 1'b0;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_cnt_load  = 1'b1;
          end
        end else begin
          w_cnt_load = 1'b0;
        end
      end
      ST_GATE_OFF: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_SWITCH;
          w_sel_nxt   = r_tgt;
          w_cnt_load  = 1'b1;
        end else begin
          w_state_nxt = ST_GATE_OFF;
        end
      end
      ST_SWITCH: begin
        if (!w_tgt_act) begin
          w_state_nxt = ST_REVERT;
          w_sel_nxt   = r_prev;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_GATE_ON;
          w_gate_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_SWITCH;
        end
      end
      ST_REVERT: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_IDLE;
          w_gate_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = ST_REVERT;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_gate_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b1;
        w_cnt_load  = 1'b1;
      end
    endcase
  end

  // decode the next select so SEL and SEL_OH update on the same edge
  always_comb begin
    w_idx               = {IDX_W{1'b0}};
    w_idx[SEL_W-1:0]    = w_sel_nxt;
  end

  assign w_oh_full   = onehot_dec(w_idx);
  assign w_unused_oh = ^w_oh_full;

  // state and output registers
  always_ff @(posedge QCK) begin
    if (QRT) begin
      r_state   <= ST_INIT;
      r_sel     <= DEF_SEL;
      r_sel_oh  <= DEF_OH;
      r_tgt     <= DEF_SEL;
      r_prev    <= DEF_SEL;
      r_gate_en <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_sel_oh  <= w_oh_full[N_SRC-1:0];
      r_tgt     <= w_tgt_nxt;
      r_prev    <= w_prev_nxt;
      r_gate_en <= w_gate_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign REQ_READY = r_ready;
  assign SEL       = r_sel;
  assign SEL_OH    = r_sel_oh;
  assign GATE_EN   = r_gate_en;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: tb/tb_gmux_sel_seq.sv
// Directed bench for gmux_sel_seq: request table plus hand-written switch/revert/reset sequences.
module tb_gmux_sel_seq;

  logic       QCK = 1'b0;
  logic       QRT;
  logic       REQ_VALID;
  logic [1:0] REQ_SRC;
  logic       REQ_READY;
  logic [3:0] SRC_ACTIVE;
  logic [1:0] SEL;
  logic [3:0] SEL_OH;
  logic       GATE_EN;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  logic       r3_valid;
  logic [1:0] r3_src;
  logic       r3_ready;
  logic [2:0] r3_act;
  logic [1:0] r3_sel;
  logic [2:0] r3_oh;
  logic       r3_gate;
  logic       r3_busy;
  logic       r3_done;
  logic       r3_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       valid;
    logic [1:0] src;
    logic [3:0] act;
    logic       e_done;
    logic       e_err;
  } vec_t;

  always #5 QCK = ~QCK;

  gmux_sel_seq #(
    .N_SRC      (4),
    .SETTLE_CYC (4),
    .DEF_SRC    (0)
  ) u_dut (
    .QCK        (QCK),
    .QRT        (QRT),
    .REQ_VALID  (REQ_VALID),
    .REQ_SRC    (REQ_SRC),
    .REQ_READY  (REQ_READY),
    .SRC_ACTIVE (SRC_ACTIVE),
    .SEL        (SEL),
    .SEL_OH     (SEL_OH),
    .GATE_EN    (GATE_EN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  gmux_sel_seq #(
    .N_SRC      (3),
    .SETTLE_CYC (4),
    .DEF_SRC    (0)
  ) u_dut3 (
    .QCK        (QCK),
    .QRT        (QRT),
    .REQ_VALID  (r3_valid),
    .REQ_SRC    (r3_src),
    .REQ_READY  (r3_ready),
    .SRC_ACTIVE (r3_act),
    .SEL        (r3_sel),
    .SEL_OH     (r3_oh),
    .GATE_EN    (r3_gate),
    .BUSY       (r3_busy),
    .DONE       (r3_done),
    .ERR        (r3_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic nedge();
    @(negedge QCK);
  endtask

  task automatic exp_main(input string tag, input logic [1:0] e_sel, input logic e_gate,
                          input logic e_ready, input logic e_done, input logic e_err);
    logic [3:0] e_oh;
    e_oh = 4'b0001 << e_sel;
    chk({tag, ".sel"},   32'(SEL),       32'(e_sel));
    chk({tag, ".oh"},    32'(SEL_OH),    32'(e_oh));
    chk({tag, ".gate"},  32'(GATE_EN),   32'(e_gate));
    chk({tag, ".ready"}, 32'(REQ_READY), 32'(e_ready));
    chk({tag, ".busy"},  32'(BUSY),      32'(!e_ready));
    chk({tag, ".done"},  32'(DONE),      32'(e_done));
    chk({tag, ".err"},   32'(ERR),       32'(e_err));
  endtask

  initial begin
    vec_t tbl [5];
    tbl[0] = '{1'b1, 2'd0, 4'b1111, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 4'b0111, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 2'd2, 4'b1111, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd1, 4'b1101, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 2'd0, 4'b1110, 1'b0, 1'b1};

    QRT        = 1'b1;
    REQ_VALID  = 1'b0;
    REQ_SRC    = 2'd0;
    SRC_ACTIVE = 4'b1111;
    r3_valid   = 1'b0;
    r3_src     = 2'd0;
    r3_act     = 3'b111;

    // reset, then release: 4 gated cycles, then idle with gate on
    nedge();
    nedge();
    QRT = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) nedge();
      exp_main($sformatf("init%0d", k), 2'd0, (k == 5), (k == 5), 1'b0, 1'b0);
    end
    chk("init.dut3_gate", 32'(r3_gate), 32'd1);

    // single-cycle request outcomes from SEL=0
    for (int i = 0; i < 5; i++) begin
      REQ_VALID  = tbl[i].valid;
      REQ_SRC    = tbl[i].src;
      SRC_ACTIVE = tbl[i].act;
      nedge();
      exp_main($sformatf("tbl%0d", i), 2'd0, 1'b1, 1'b1, tbl[i].e_done, tbl[i].e_err);
      REQ_VALID  = 1'b0;
      SRC_ACTIVE = 4'b1111;
      nedge();
      exp_main($sformatf("tbl%0d_after", i), 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // out-of-range index on a 3-source build
    r3_valid = 1'b1;
    r3_src   = 2'd3;
    nedge();
    chk("oob.err",   32'(r3_err),   32'd1);
    chk("oob.done",  32'(r3_done),  32'd0);
    chk("oob.sel",   32'(r3_sel),   32'd0);
    chk("oob.oh",    32'(r3_oh),    32'd1);
    chk("oob.gate",  32'(r3_gate),  32'd1);
    chk("oob.ready", 32'(r3_ready), 32'd1);
    r3_valid = 1'b0;
    nedge();
    chk("oob.err_after", 32'(r3_err), 32'd0);

    // full switch 0 -> 2
    REQ_VALID = 1'b1;
    REQ_SRC   = 2'd2;
    for (int k = 1; k <= 10; k++) begin
      nedge();
      exp_main($sformatf("sw%0d", k), (k >= 5) ? 2'd2 : 2'd0, (k >= 9), (k >= 9), (k == 9), 1'b0);
      if (k == 1) REQ_VALID = 1'b0;
    end

    // switch 2 -> 1 aborted by source 1 dropping while the select settles
    REQ_VALID = 1'b1;
    REQ_SRC   = 2'd1;
    for (int k = 1; k <= 12; k++) begin
      nedge();
      exp_main($sformatf("rv%0d", k), (k == 5 || k == 6) ? 2'd1 : 2'd2,
               (k >= 11), (k >= 11), 1'b0, (k == 11));
      if (k == 1) REQ_VALID = 1'b0;
      if (k == 6) SRC_ACTIVE = 4'b1101;
    end
    SRC_ACTIVE = 4'b1111;

    // reset asserted mid-switch 2 -> 3
    REQ_VALID = 1'b1;
    REQ_SRC   = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      nedge();
      exp_main($sformatf("mr%0d", k), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 1) REQ_VALID = 1'b0;
    end
    QRT = 1'b1;
    nedge();
    exp_main("mr4", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    QRT = 1'b0;
    for (int k = 5; k <= 8; k++) begin
      nedge();
      exp_main($sformatf("mr%0d", k), 2'd0, (k == 8), (k == 8), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gmux_sel_seq.md
Name: gmux_sel_seq

Overview:
- Parametrised select sequencer for a cascade of global clock muxes.
- Replaces a raw static select pin with a handshaked, gated switch among N_SRC clock sources: gate off, let settle, change select, let settle, gate on.
- Sits in the clock-control fabric, on the control clock domain.
- Drives the mux select lines and the global buffer gate enable.

Parameters:
- N_SRC, 4, number of selectable clock sources (2..16).
- SEL_W, $clog2(N_SRC), width of the binary source index.
- SETTLE_CYC, 4, cycles to wait after gate-off and after select change (1..255).
- DEF_SRC, 0, source selected out of reset.

Ports:
- QCK  input  1  control clock.
- QRT  input  1  reset, synchronous, active-high.
- REQ_VALID  input  1  switch request valid.
- REQ_SRC  input  SEL_W  requested source index.
- REQ_READY  output  1  sequencer can accept a request.
- SRC_ACTIVE  input  N_SRC  per-source clock-present status.
- SEL  output  SEL_W  current binary select (registered).
- SEL_OH  output  N_SRC  one-hot decode of SEL (registered), for per-stage mux select pins.
- GATE_EN  output  1  global buffer enable (registered).
- BUSY  output  1  sequence in progress.
- DONE  output  1  one-cycle pulse when a request completes successfully.
- ERR  output  1  one-cycle pulse when a request is rejected or aborted.

Behaviour:
- Reset (QRT high at a QCK edge):
  - Next cycle: SEL=DEF_SRC, SEL_OH=1<<DEF_SRC, GATE_EN=0, REQ_READY=0, BUSY=1, DONE=0, ERR=0, state INIT.
  - Reset mid-sequence aborts the sequence with no DONE/ERR pulse.
- INIT:
  - Count SETTLE_CYC cycles after reset release.
  - Then GATE_EN=1, BUSY=0, REQ_READY=1, go to IDLE. No DONE.
- IDLE:
  - REQ_READY=1, BUSY=0.
  - A request is accepted at an edge where REQ_VALID && REQ_READY. Call that edge t.
  - Accepted requests are checked at acceptance in this order:
    - REQ_SRC >= N_SRC: ERR pulse at t+1, no other change, stay IDLE.
    - SRC_ACTIVE[REQ_SRC]==0: ERR pulse at t+1, stay IDLE.
    - REQ_SRC==SEL: DONE pulse at t+1, GATE_EN stays 1, stay IDLE.
    - Otherwise latch the target and the previous SEL; go to GATE_OFF.
- GATE_OFF:
  - GATE_EN=0 from t+1.
  - REQ_READY=0, BUSY=1.
  - Wait SETTLE_CYC cycles.
- SWITCH:
  - SEL/SEL_OH take the target at t+1+SETTLE_CYC.
  - Wait SETTLE_CYC cycles.
  - If SRC_ACTIVE[target] drops during this wait:
    - Restore the previous SEL on the next cycle.
    - Wait SETTLE_CYC.
    - GATE_EN=1, ERR pulse, go to IDLE.
- GATE_ON:
  - GATE_EN=1 and DONE pulse at t+1+2*SETTLE_CYC.
  - REQ_READY=1 in the same cycle; go to IDLE.
- Requests during BUSY are not accepted (REQ_READY=0). The requester holds REQ_VALID; there is no queueing.
- SRC_ACTIVE of the current source dropping while IDLE causes no autonomous action.
- SEL and SEL_OH are always mutually consistent and change only while GATE_EN=0.
- DONE and ERR are never high in the same cycle.
- The settle counter is 8 bits and saturates: it does not wrap.

Decomposition:
- Shared package gmux_pkg:
  - state enum: INIT, IDLE, GATE_OFF, SWITCH, REVERT, GATE_ON.
  - SETTLE counter width constant (8).
  - one-hot decode function, used for SEL_OH.
- Sub-module gmux_settle_cnt:
  - load/start input, done output, SETTLE_CYC parameter.
  - instantiated once and reused by INIT, GATE_OFF, SWITCH and REVERT.

Test Plan (N_SRC=4, SETTLE_CYC=4, DEF_SRC=0):
- Reset, then release:
  - SEL=0, SEL_OH=4'b0001, GATE_EN=0 for 4 cycles.
  - Then GATE_EN=1, REQ_READY=1, no DONE/ERR.
- Request src 2 with SRC_ACTIVE=4'b1111, accepted at t:
  - GATE_EN=0 at t+1.
  - SEL=2, SEL_OH=4'b0100 at t+5.
  - GATE_EN=1 and DONE at t+9.
  - REQ_READY=0 over t+1..t+8.
- Request src 0 while SEL=0: DONE at t+1, GATE_EN stays 1, SEL unchanged.
- Request src 3 with SRC_ACTIVE=4'b0111: ERR at t+1, SEL and GATE_EN unchanged.
- Invalid index (N_SRC=3 build, REQ_SRC=3): ERR at t+1, no change.
- Request src 1 from SEL=2, drop SRC_ACTIVE[1] at t+6:
  - SEL returns to 2 at t+7.
  - GATE_EN=1 and ERR at t+11, no DONE.
- Assert QRT at t+3 during a switch:
  - SEL=0 and GATE_EN=0 next cycle.
  - INIT sequence repeats, no DONE/ERR pulse.
